// File: rtl/i2c_eeprom_target_pkg.sv
// i2c_eeprom_target_pkg: shared state encoding and protocol constants for the I2C EEPROM target.
package i2c_eeprom_target_pkg;
  typedef enum logic [8:0] {
    S_IDLE = 9'b000000001,
    S_DEV  = 9'b000000010,
    S_AHI  = 9'b000000100,
    S_ALO  = 9'b000001000,
    S_WR   = 9'b000010000,
    S_RD   = 9'b000100000,
    S_RACK = 9'b001000000,
    S_ACK  = 9'b010000000,
    S_WAIT = 9'b100000000
  } state_t;
  localparam logic [6:0] DEF_DEV_ADDR = 7'b1010001;
  localparam logic [3:0] BYTE_BITS = 4'd8;
endpackage

// File: rtl/i2c_eeprom_target_if.sv
// i2c_eeprom_target_if: bus clock plus write/read observe signals of the EEPROM target.
//   scl              bus clock from the master
//   busy             target addressed, until STOP or abort
//   wr_stb/addr/data committed-byte observe port
//   rd_stb           byte loaded for transmission
interface i2c_eeprom_target_if #(parameter int ADDR_W = 8);
  logic scl;
  logic busy;
  logic wr_stb;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0] wr_data;
  logic rd_stb;
  modport master (output scl, input busy, wr_stb, wr_addr, wr_data, rd_stb);
  modport slave (input scl, output busy, wr_stb, wr_addr, wr_data, rd_stb);
endinterface

// File: rtl/i2c_eeprom_target_line_sync.sv
// i2c_eeprom_target_line_sync: 2-FF synchronizers for scl/sda plus edge and START/STOP detection.
//   clk, nrst           system clock, async active-low reset
//   scl, sda            raw bus pins
//   scl_rise, scl_fall  one-cycle synchronized SCL edges
//   start_det, stop_det sda fall / rise while scl high
//   sda_s               synchronized sda
module i2c_eeprom_target_line_sync (
  input  logic clk,
  input  logic nrst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);
  logic [2:0] scl_q, sda_q;
  // Reset to the idle-bus level so leaving reset never looks like an edge or START.
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
    end
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign start_det = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop_det  = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
  assign sda_s     = sda_q[1];
endmodule

// File: rtl/i2c_eeprom_target.sv
// i2c_eeprom_target: oversampled I2C target emulating a 24LC0x-style EEPROM (byte/sequential write, random/sequential read).
//   clk, nrst  system clock, async active-low reset
//   sda        open-drain data line, driven low or released only
//   bus        scl in; busy, wr_stb/wr_addr/wr_data, rd_stb out
module i2c_eeprom_target
  import i2c_eeprom_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
  parameter int ADDR_W = 8
) (
  input  logic clk,
  input  logic nrst,
  inout  wire  sda,
  i2c_eeprom_target_if.slave bus
);
  state_t st, st_n, nxt, nxt_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] sr, sr_n, rx, rd_byte, wd, wd_n;
  logic [ADDR_W-1:0] ptr, ptr_n, wa, wa_n;
  logic [15:0] p16;
  logic oe, oe_n, busy, busy_n, wstb, wstb_n, rstb, rstb_n, got, got_n, we, load;
  logic scl_rise, scl_fall, start_det, stop_det, sda_s;
  logic [7:0] mem [2**ADDR_W];
  i2c_eeprom_target_line_sync u_sync (
    .clk(clk), .nrst(nrst), .scl(bus.scl), .sda(sda),
    .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_det(start_det), .stop_det(stop_det), .sda_s(sda_s)
  );
  assign rx = {sr[6:0], sda_s};
  assign rd_byte = mem[ptr];
  assign p16 = 16'(ptr);
  assign sda = oe ? 1'b0 : 1'bz;
  assign bus.busy = busy;
  assign bus.wr_stb = wstb;
  assign bus.wr_addr = wa;
  assign bus.wr_data = wd;
  assign bus.rd_stb = rstb;
  always_comb begin
    st_n = st;
    nxt_n = nxt;
    cnt_n = cnt;
    sr_n = sr;
    ptr_n = ptr;
    oe_n = oe;
    busy_n = busy;
    got_n = got;
    wa_n = wa;
    wd_n = wd;
    wstb_n = 1'b0;
    rstb_n = 1'b0;
    we = 1'b0;
    load = 1'b0;
    if (stop_det) begin
      st_n = S_IDLE;
      oe_n = 1'b0;
      busy_n = 1'b0;
    end else if (start_det) begin
      st_n = S_DEV;
      cnt_n = '0;
      oe_n = 1'b0;
    end else if (st inside {S_DEV, S_AHI, S_ALO, S_WR}) begin
      if (scl_rise && cnt != BYTE_BITS) begin
        sr_n = rx;
        cnt_n = cnt + 1'b1;
        // Commit on the 8th sample so a STOP mid-byte leaves memory untouched.
        if (st == S_WR && cnt == BYTE_BITS - 1'b1) begin
          we = 1'b1;
          wstb_n = 1'b1;
          wa_n = ptr;
          wd_n = rx;
          ptr_n = ptr + 1'b1;
        end
      end else if (scl_fall && cnt == BYTE_BITS) begin
        if (st == S_DEV && sr[7:1] != DEV_ADDR) begin
          st_n = S_IDLE;
          busy_n = 1'b0;
        end else begin
          st_n = S_ACK;
          oe_n = 1'b1;
          busy_n = 1'b1;
          nxt_n = st == S_DEV ? (sr[0] ? S_RD : S_AHI) : st == S_AHI ? S_ALO : S_WR;
        end
        // High byte only reaches pointer bits above 7; truncation drops it when ADDR_W <= 8.
        ptr_n = st == S_AHI ? ADDR_W'({sr, p16[7:0]}) : st == S_ALO ? ADDR_W'({p16[15:8], sr}) : ptr;
      end
    end else if (st == S_ACK) begin
      if (scl_fall) begin
        oe_n = 1'b0;
        st_n = nxt;
        cnt_n = '0;
        got_n = 1'b0;
        load = nxt == S_RD;
      end
    end else if (st == S_RD) begin
      if (scl_rise) cnt_n = cnt + 1'b1;
      else if (scl_fall) begin
        if (cnt == BYTE_BITS) begin
          oe_n = 1'b0;
          st_n = S_RACK;
          got_n = 1'b0;
        end else begin
          sr_n = {sr[6:0], 1'b0};
          oe_n = ~sr[6];
        end
      end
    end else if (st == S_RACK) begin
      // Master's ACK bit is taken on the rise; the next byte is only presented on the following fall.
      if (scl_rise) begin
        if (sda_s) st_n = S_WAIT;
        else got_n = 1'b1;
      end else if (scl_fall && got) load = 1'b1;
    end
    if (load) begin
      st_n = S_RD;
      sr_n = rd_byte;
      oe_n = ~rd_byte[7];
      ptr_n = ptr + 1'b1;
      rstb_n = 1'b1;
      cnt_n = '0;
    end
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      st <= S_IDLE;
      nxt <= S_IDLE;
      cnt <= '0;
      sr <= '0;
      ptr <= '0;
      oe <= 1'b0;
      busy <= 1'b0;
      got <= 1'b0;
      wa <= '0;
      wd <= '0;
      wstb <= 1'b0;
      rstb <= 1'b0;
    end else begin
      st <= st_n;
      nxt <= nxt_n;
      cnt <= cnt_n;
      sr <= sr_n;
      ptr <= ptr_n;
      oe <= oe_n;
      busy <= busy_n;
      got <= got_n;
      wa <= wa_n;
      wd <= wd_n;
      wstb <= wstb_n;
      rstb <= rstb_n;
    end
  always_ff @(posedge clk)
    if (we) mem[ptr] <= rx;
endmodule

// File: doc/i2c_eeprom_target.md
# i2c_eeprom_target

I2C target (responder) that emulates a 24LC0x-style EEPROM on the board's two-wire bus. It answers byte writes and random reads from the team's FPGA-side I2C controller, whether that controller runs in the same fabric or on an external master. Bus pins are oversampled on the system clock. Storage is an internal byte array, and a write-observe port exposes each stored byte. Its main uses are loopback testing of the I2C controller and serving calibration data without a physical EEPROM.

## Interface
Parameters:
- `SYS_FREQ`, 12_090_000: system clock in Hz; informational, used only for the SCL-rate assertion in the bench.
- `DEV_ADDR`, 7'b1010001: 7-bit device address the block acknowledges.
- `ADDR_W`, 8: memory address width; memory depth is 2**ADDR_W bytes.

Ports:
- `clk`, input, 1: system clock.
- `nrst`, input, 1: reset, asynchronous, active-low.
- `scl`, input, 1: bus clock; the block never stretches it.
- `sda`, inout, 1: open-drain data line; the block only drives 0 or releases (z).
- `busy`, output, 1: high from address match until STOP or abort.
- `wr_stb`, output, 1: one-cycle pulse when a data byte is committed to memory.
- `wr_addr`, output, ADDR_W: address of the committed byte.
- `wr_data`, output, 8: value of the committed byte.
- `rd_stb`, output, 1: one-cycle pulse when a byte is loaded for transmission.

## Operation
Line conditioning:
- `scl` and `sda` each pass through a 2-FF synchronizer, then a third register for edge detection.
- START: sda falls while scl is high. STOP: sda rises while scl is high. Both are detected from the synchronized signals.
- Bits are sampled on the synchronized SCL rising edge. sda_out changes only on the synchronized SCL falling edge.

Protocol (MSB first):
- Transaction: START, device byte, two address bytes, then data.
- The first address byte is the page/high byte. It is ACKed and ignored when ADDR_W ≤ 8; otherwise its bits [ADDR_W-9:0] form the pointer MSBs.
- The second address byte loads the pointer's low 8 bits.

States:
- IDLE: sda released. Any START goes to DEV.
- DEV: shift 8 bits.
  - addr == DEV_ADDR and R/W=0: ACK, then go to AHI.
  - addr == DEV_ADDR and R/W=1: ACK, then go to RD.
  - mismatch: no ACK, return to IDLE.
- AHI → ACK → ALO → ACK → WR.
- WR: each received byte is written to mem[ptr]. `wr_stb` pulses once after bit 0 is sampled. Then ACK and ptr++.
- RD:
  - After the ACK slot, on SCL fall, load mem[ptr] into the shift register, pulse `rd_stb`, and increment ptr.
  - Shift out bits 7..0, then release sda for the master ACK bit.
  - Master ACK (0): load the next byte. Master NACK (1): go to WAIT.
- WAIT: released; only START/STOP are acted on.
- ACK slot: drive sda=0 from the SCL fall after bit 0 until the next SCL fall.

Boundary conditions:
- STOP in any state: go to IDLE, release sda. Any partial byte is discarded and not written.
- START in any non-IDLE state (repeated start): go to DEV; ptr is retained. This is required for random read: a write to AHI/ALO, repeated START, then a read.
- Pointer wraps from 2**ADDR_W-1 to 0 for both reads and writes.
- Memory is not reset. All other registers reset on nrst.

## Timing
Reset values: sda released, `busy`=0, `wr_stb`=0, `rd_stb`=0, `wr_addr`=0, `wr_data`=0, ptr=0, state IDLE.

Latencies:
- Sample of a bit: 3 clk after the SCL rising edge on the pin.
- sda driven or released: within 4 clk of the SCL falling edge on the pin, so data is valid well before the master's 3/4-period sample point.
- `wr_stb`: asserted 1 clk after the 8th data bit is sampled. `wr_addr`/`wr_data` are held until the next strobe.

SCL requirements:
- SCL high and low phases must each be at least 8 clk. The controller's 100 kHz at 12.09 MHz gives about 60 clk per phase.
- Glitches shorter than 2 clk are not filtered.

Reset mid-transfer: sda is released immediately (asynchronously) and the state returns to IDLE.

## Structure
- Shared Verilog header `i2c_defs.vh` holds the default device address 7'b1010001, the state encodings (one-hot, 9 states: IDLE, DEV, AHI, ALO, WR, RD, RACK, ACK, WAIT) and the bit-count constants. The same header is used by the I2C controller.
- One sub-module, `i2c_line_sync`: synchronizers plus edge detection. Outputs `scl_rise`, `scl_fall`, `start_det`, `stop_det` and `sda_s`.

## Test plan
- Byte write: controller writes waddr=0x12, wdata=0xA5. Expect 4 ACKs, `wr_stb` once with `wr_addr`=0x12 and `wr_data`=0xA5, and `busy`=0 after STOP.
- Random read: after the write above, controller reads raddr=0x12. Expect `rdata`=0xA5, one `rd_stb`, and sda released during the master NACK.
- Address mismatch: device byte 0xA0 (7'b1010000). Expect no ACK (sda high in slot 9), no `wr_stb`, and state IDLE.
- Wrap and sequential: write 0x11 to 0xFF, then continue with 0x22 in the same transaction. Expect mem[0xFF]=0x11 and mem[0x00]=0x22. A sequential read from 0xFF with master ACK returns 0x11 then 0x22.
- Abort: STOP after 4 data bits of a write byte. Expect no `wr_stb` and the next transaction to work. Also assert nrst mid-read and expect sda released within the same cycle.
- Repeated START mid-write-data: expect return to DEV with ptr retained, and that the following read returns mem[ptr].
